// File: rtl/nios2_secure_memory_timer_sched.sv
// Round-robin scheduler that shares one 16-bit-register interval timer among NUM_REQ one-shot delay requesters.
// Optional build macro TIMER_SCHED_CANCEL_EN: a requester may abort its delay by dropping req while waiting.
module nios2_secure_memory_timer_sched #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_period,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [2:0]             tmr_address,
    output logic                   tmr_chipselect,
    output logic                   tmr_write_n,
    output logic [15:0]            tmr_writedata,
    input  logic                   tmr_irq
);

    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1 = PW + 1;

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  ADDR_PERLO  = 3'd2;
    localparam logic [2:0]  ADDR_PERHI  = 3'd3;
    localparam logic [15:0] CTRL_STOP   = 16'h0008;
    localparam logic [15:0] CTRL_START  = 16'h0005;

    typedef enum logic [3:0] {
        IDLE,
        ARB,
        STOP,
        WR_PL,
        WR_PH,
        CLR,
        START,
        WAIT,
        ACK,
        DONE
`ifdef TIMER_SCHED_CANCEL_EN
        , CANCEL
`endif
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     cur_g;
    logic [PW-1:0]     g_next;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     cand;
    logic [PW:0]       cand_sum;
    logic              pick_found;
    logic [31:0]       pick_period;
    logic [31:0]       period_q;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [15:0]       wr_data;
    logic              cancelled;

    // Search starts at the rr pointer so the last winner is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + PW1'(k);
            if (cand_sum >= PW1'(NUM_REQ)) begin
                cand_sum = cand_sum - PW1'(NUM_REQ);
            end
            cand = cand_sum[PW-1:0];
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_period = 32'h0000_0000;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == PW'(k)) begin
                pick_period = req_period[32*k +: 32];
            end
        end
    end

    assign g_next = (cur_g == PW'(NUM_REQ - 1)) ? '0 : cur_g + PW'(1);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (|req) state_next = ARB;
            ARB: begin
                if (!pick_found) begin
                    state_next = IDLE;
                end else if (pick_period == 32'h0000_0000) begin
                    state_next = DONE;
                end else begin
                    state_next = STOP;
                end
            end
            STOP:  state_next = WR_PL;
            WR_PL: state_next = WR_PH;
            WR_PH: state_next = CLR;
            CLR:   state_next = START;
            START: state_next = WAIT;
            WAIT: begin
                if (tmr_irq) begin
                    state_next = ACK;
`ifdef TIMER_SCHED_CANCEL_EN
                end else if (!req[cur_g]) begin
                    state_next = CANCEL;
`endif
                end
            end
`ifdef TIMER_SCHED_CANCEL_EN
            CANCEL: state_next = ACK;
            ACK:    state_next = cancelled ? IDLE : DONE;
`else
            ACK:    state_next = DONE;
`endif
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Timer write issued by each state; registered below, so it appears one cycle after the state.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 16'h0000;
        case (state)
            STOP:  begin wr_en = 1'b1; wr_addr = ADDR_CTRL;   wr_data = CTRL_STOP;       end
            WR_PL: begin wr_en = 1'b1; wr_addr = ADDR_PERLO;  wr_data = period_q[15:0];  end
            WR_PH: begin wr_en = 1'b1; wr_addr = ADDR_PERHI;  wr_data = period_q[31:16]; end
            CLR:   begin wr_en = 1'b1; wr_addr = ADDR_STATUS; wr_data = 16'h0000;        end
            START: begin wr_en = 1'b1; wr_addr = ADDR_CTRL;   wr_data = CTRL_START;      end
            ACK:   begin wr_en = 1'b1; wr_addr = ADDR_STATUS; wr_data = 16'h0000;        end
`ifdef TIMER_SCHED_CANCEL_EN
            CANCEL: begin wr_en = 1'b1; wr_addr = ADDR_CTRL;  wr_data = CTRL_STOP;       end
`endif
            default: ;
        endcase
    end

`ifdef TIMER_SCHED_CANCEL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cancelled <= 1'b0;
        end else if (state == CANCEL) begin
            cancelled <= 1'b1;
        end else if (state == ACK) begin
            cancelled <= 1'b0;
        end
    end
`else
    assign cancelled = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr         <= '0;
            cur_g          <= '0;
            period_q       <= '0;
            grant          <= '0;
            done           <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= 3'd0;
            tmr_writedata  <= 16'h0000;
        end else begin
            done           <= '0;
            tmr_chipselect <= wr_en;
            tmr_write_n    <= ~wr_en;
            tmr_address    <= wr_addr;
            tmr_writedata  <= wr_data;
            if (state == ARB && pick_found) begin
                cur_g    <= pick_idx;
                period_q <= pick_period;
                grant    <= NUM_REQ'(1) << pick_idx;
            end
            // A cancelled delay releases the timer without a done pulse but still rotates priority.
            if (state == DONE || (state == ACK && cancelled)) begin
                done   <= (state == DONE) ? grant : '0;
                grant  <= '0;
                rr_ptr <= g_next;
            end
        end
    end

endmodule
